// File: rtl/mc_pkg.sv
// Shared types and default sizes for the Julia master-controller dispatch slice.
package mc_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPATCH = 2'd1,
    DRAIN    = 2'd2,
    DONE     = 2'd3
  } mc_state_e;

  localparam int unsigned MC_NUM_WORKERS = 4;
  localparam int unsigned MC_NUM_JOBS    = 480;
  localparam int unsigned MC_JOB_W       = 16;
  localparam int unsigned MC_TIMEOUT     = 4096;

  // Index width for an n-entry vector, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mc_dispatch_if.sv
// Worker-side handshake bundle: job launch, result write-back grant and error flags.
interface mc_dispatch_if #(
  parameter int unsigned NUM_WORKERS = 4,
  parameter int unsigned JOB_W       = 16
);
  localparam int unsigned WB_W = mc_pkg::idx_w(NUM_WORKERS);

  logic [NUM_WORKERS-1:0] JW_ready;
  logic [NUM_WORKERS-1:0] JW_start;
  logic [JOB_W-1:0]       job_id;
  logic [NUM_WORKERS-1:0] JW_done;
  logic [NUM_WORKERS-1:0] MC_busy;
  logic [WB_W-1:0]        wb_worker;
  logic [NUM_WORKERS-1:0] timeout_err;

  modport master (
    input  JW_ready, JW_done,
    output JW_start, job_id, MC_busy, wb_worker, timeout_err
  );

  modport slave (
    output JW_ready, JW_done,
    input  JW_start, job_id, MC_busy, wb_worker, timeout_err
  );
endinterface

// File: rtl/mc_dispatch_rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting after the last winner; pointer moves on advance.
module rr_arbiter #(
  parameter int unsigned WIDTH = 4,
  localparam int unsigned IDX_W = mc_pkg::idx_w(WIDTH)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [WIDTH-1:0] req,
  input  logic             advance,
  output logic [WIDTH-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid
);
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    cand      = '0;
    for (int unsigned k = 0; k < WIDTH; k++) begin
      cand = IDX_W'((32'(ptr_q) + k) % WIDTH);
      if (!gnt_valid && req[cand]) begin
        gnt_valid  = 1'b1;
        gnt[cand]  = 1'b1;
        gnt_idx    = cand;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance && gnt_valid) begin
      ptr_d = (gnt_idx == IDX_W'(WIDTH - 1)) ? '0 : gnt_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
endmodule

// File: rtl/mc_dispatch.sv
// Frame-level job dispatcher and write-back arbiter for NUM_WORKERS Julia workers.
// Optional watchdog per worker is enabled by defining MC_TIMEOUT_EN.
module mc_dispatch
  import mc_pkg::*;
#(
  parameter int unsigned NUM_WORKERS = MC_NUM_WORKERS,
  parameter int unsigned NUM_JOBS    = MC_NUM_JOBS,
  parameter int unsigned JOB_W       = MC_JOB_W,
  parameter int unsigned TIMEOUT     = MC_TIMEOUT
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          frame_start,
  output logic          frame_done,
  output logic          busy,
  mc_dispatch_if.master wif
);
  localparam int unsigned      WB_W   = idx_w(NUM_WORKERS);
  localparam int unsigned      CNT_W  = JOB_W + 1;
  localparam logic [CNT_W-1:0] JOBS_C = CNT_W'(NUM_JOBS);

  mc_state_e              state_q, state_d;
  logic [CNT_W-1:0]       next_job_q, next_job_d;
  logic [CNT_W-1:0]       completed_q, completed_d;
  logic [NUM_WORKERS-1:0] own_q, own_d;
  logic [NUM_WORKERS-1:0] start_q, start_d;
  logic [NUM_WORKERS-1:0] mc_busy_q, mc_busy_d;
  logic [JOB_W-1:0]       job_id_q, job_id_d;
  logic [WB_W-1:0]        wb_worker_q, wb_worker_d;
  logic                   frame_done_q, frame_done_d;
  logic                   busy_q, busy_d;

  logic [NUM_WORKERS-1:0] gnt_active, dsp_req, dsp_gnt, wb_req, wb_gnt;
  logic [NUM_WORKERS-1:0] tmo_fire, tmo_err;
  logic [WB_W-1:0]        dsp_idx, wb_idx;
  logic                   dsp_en, dsp_valid, wb_valid;

  // A worker whose MC_busy bit is low right now is mid-handoff: its JW_done is
  // still settling, so it is neither re-launched nor re-granted this cycle.
  assign gnt_active = ~mc_busy_q;
  assign dsp_en     = (state_q == DISPATCH) && (next_job_q != JOBS_C);
  assign dsp_req    = dsp_en ? (wif.JW_ready & ~own_q & ~gnt_active & ~tmo_err) : '0;
  assign wb_req     = wif.JW_done & own_q & ~gnt_active & ~tmo_fire;

  rr_arbiter #(.WIDTH(NUM_WORKERS)) u_dsp_arb (
    .clk(clk), .n_rst(n_rst), .req(dsp_req), .advance(dsp_en),
    .gnt(dsp_gnt), .gnt_idx(dsp_idx), .gnt_valid(dsp_valid)
  );

  rr_arbiter #(.WIDTH(NUM_WORKERS)) u_wb_arb (
    .clk(clk), .n_rst(n_rst), .req(wb_req), .advance(1'b1),
    .gnt(wb_gnt), .gnt_idx(wb_idx), .gnt_valid(wb_valid)
  );

`ifdef MC_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT) + 1;

  for (genvar gi = 0; gi < NUM_WORKERS; gi++) begin : g_tmo
    logic [TMO_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    assign tmo_fire[gi] = own_q[gi] && (cnt_q == TMO_W'(TIMEOUT - 1));
    assign tmo_err[gi]  = err_q;

    always_comb begin
      cnt_d = cnt_q;
      err_d = err_q | tmo_fire[gi];
      if (start_d[gi]) cnt_d = '0;
      else if (own_q[gi]) cnt_d = cnt_q + TMO_W'(1);
    end

    always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
        cnt_q <= '0;
        err_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        err_q <= err_d;
      end
    end
  end
`else
  assign tmo_fire = '0;
  assign tmo_err  = '0;
`endif

  always_comb begin
    state_d      = state_q;
    next_job_d   = next_job_q;
    own_d        = own_q;
    start_d      = '0;
    job_id_d     = job_id_q;
    mc_busy_d    = '1;
    wb_worker_d  = wb_worker_q;
    frame_done_d = 1'b0;
    busy_d       = busy_q;
    // Timed-out jobs count as completed so the frame can still finish.
    completed_d  = completed_q + CNT_W'(wb_valid) + CNT_W'($countones(tmo_fire));

    if (dsp_valid) begin
      start_d[dsp_idx] = 1'b1;
      job_id_d         = next_job_q[JOB_W-1:0];
      next_job_d       = next_job_q + CNT_W'(1);
      own_d            = own_d | dsp_gnt;
    end
    if (wb_valid) begin
      mc_busy_d   = ~wb_gnt;
      wb_worker_d = wb_idx;
    end
    own_d = own_d & ~wb_gnt & ~tmo_fire;

    unique case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d     = DISPATCH;
          next_job_d  = '0;
          completed_d = '0;
          busy_d      = 1'b1;
        end
      end
      DISPATCH: if (next_job_q == JOBS_C) state_d = DRAIN;
      DRAIN: begin
        if (completed_q == JOBS_C) begin
          state_d      = DONE;
          frame_done_d = 1'b1;
          busy_d       = 1'b0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      next_job_q   <= '0;
      completed_q  <= '0;
      own_q        <= '0;
      start_q      <= '0;
      mc_busy_q    <= '1;
      job_id_q     <= '0;
      wb_worker_q  <= '0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      next_job_q   <= next_job_d;
      completed_q  <= completed_d;
      own_q        <= own_d;
      start_q      <= start_d;
      mc_busy_q    <= mc_busy_d;
      job_id_q     <= job_id_d;
      wb_worker_q  <= wb_worker_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  assign wif.JW_start    = start_q;
  assign wif.job_id      = job_id_q;
  assign wif.MC_busy     = mc_busy_q;
  assign wif.wb_worker   = wb_worker_q;
  assign wif.timeout_err = tmo_err;
  assign frame_done      = frame_done_q;
  assign busy            = busy_q;
endmodule

// File: tb/tb_mc_dispatch.sv
// Directed bench for mc_dispatch: 4 workers, 8-job frames, optional watchdog at 16 cycles.
`timescale 1ns/1ps
module tb_mc_dispatch;
  localparam int unsigned NW  = 4;
  localparam int unsigned NJ  = 8;
  localparam int unsigned JW  = 16;
  localparam int unsigned TMO = 16;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic frame_start = 1'b0;
  logic frame_done;
  logic busy;
  logic [NW-1:0] own_tb;

  int errors = 0;
  int checks = 0;

  mc_dispatch_if #(.NUM_WORKERS(NW), .JOB_W(JW)) wif ();

  mc_dispatch #(.NUM_WORKERS(NW), .NUM_JOBS(NJ), .JOB_W(JW), .TIMEOUT(TMO)) dut (
    .clk(clk), .n_rst(n_rst), .frame_start(frame_start),
    .frame_done(frame_done), .busy(busy), .wif(wif)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    wif.JW_ready = '0;
    wif.JW_done  = '0;
    tick();
    tick();
    checks++; if (wif.JW_start !== 4'b0) begin errors++; $display("FAIL rst_start: got %b, expected 0000", wif.JW_start); end
    checks++; if (wif.job_id !== 16'd0) begin errors++; $display("FAIL rst_job_id: got %0d, expected 0", wif.job_id); end
    checks++; if (wif.MC_busy !== 4'hF) begin errors++; $display("FAIL rst_mc_busy: got %b, expected 1111", wif.MC_busy); end
    checks++; if (frame_done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_frame: done=%b busy=%b, expected 0 0", frame_done, busy); end
    checks++; if (wif.timeout_err !== 4'b0) begin errors++; $display("FAIL rst_tmo: got %b, expected 0000", wif.timeout_err); end
    n_rst = 1'b1;
    tick();
  endtask

  task automatic test_dispatch();
    logic [NW-1:0] exp;
    wif.JW_ready = 4'hF;
    frame_start  = 1'b1;
    tick();
    frame_start  = 1'b0;
    checks++; if (busy !== 1'b1 || wif.JW_start !== 4'b0) begin errors++; $display("FAIL lat1: busy=%b start=%b, expected 1 0000", busy, wif.JW_start); end
    for (int k = 0; k < 4; k++) begin
      tick();
      exp = 4'b0001 << k;
      $display("launch start=%b job=%0d", wif.JW_start, wif.job_id);
      checks++; if (wif.JW_start !== exp || wif.job_id !== JW'(k)) begin errors++; $display("FAIL dispatch_%0d: start=%b job=%0d, expected %b %0d", k, wif.JW_start, wif.job_id, exp, k); end
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++; if (wif.JW_start !== 4'b0) begin errors++; $display("FAIL no_launch_%0d: got %b, expected 0000", k, wif.JW_start); end
    end
  endtask

  task automatic test_single_grant();
    wif.JW_done = 4'b0100;
    tick();
    $display("grant busy=%b wb=%0d", wif.MC_busy, wif.wb_worker);
    checks++; if (wif.MC_busy !== 4'b1011 || wif.wb_worker !== 2'd2) begin errors++; $display("FAIL grant_w2: busy=%b wb=%0d, expected 1011 2", wif.MC_busy, wif.wb_worker); end
    wif.JW_done = 4'b0000;
    tick();
    checks++; if (wif.MC_busy !== 4'hF || wif.JW_start !== 4'b0) begin errors++; $display("FAIL grant_w2_end: busy=%b start=%b, expected 1111 0000", wif.MC_busy, wif.JW_start); end
    tick();
    checks++; if (wif.JW_start !== 4'b0100 || wif.job_id !== 16'd4) begin errors++; $display("FAIL relaunch_w2: start=%b job=%0d, expected 0100 4", wif.JW_start, wif.job_id); end
  endtask

  task automatic test_back_to_back();
    wif.JW_done = 4'b1001;
    tick();
    checks++; if (wif.MC_busy !== 4'b0111 || wif.wb_worker !== 2'd3) begin errors++; $display("FAIL b2b_first: busy=%b wb=%0d, expected 0111 3", wif.MC_busy, wif.wb_worker); end
    wif.JW_done = 4'b0001;
    tick();
    checks++; if (wif.MC_busy !== 4'b1110 || wif.wb_worker !== 2'd0) begin errors++; $display("FAIL b2b_second: busy=%b wb=%0d, expected 1110 0", wif.MC_busy, wif.wb_worker); end
    wif.JW_done = 4'b0000;
    tick();
    checks++; if (wif.MC_busy !== 4'hF) begin errors++; $display("FAIL b2b_end: busy=%b, expected 1111", wif.MC_busy); end
    checks++; if (wif.JW_start !== 4'b1000 || wif.job_id !== 16'd5) begin errors++; $display("FAIL relaunch_w3: start=%b job=%0d, expected 1000 5", wif.JW_start, wif.job_id); end
    tick();
    checks++; if (wif.JW_start !== 4'b0001 || wif.job_id !== 16'd6) begin errors++; $display("FAIL relaunch_w0: start=%b job=%0d, expected 0001 6", wif.JW_start, wif.job_id); end
  endtask

  task automatic test_full_frame();
    int launches = 7;
    int grants   = 3;
    int exp_wb   = 0;
    bit seen     = 1'b0;
    own_tb      = 4'hF;
    wif.JW_done = own_tb;
    for (int cyc = 0; cyc < 200; cyc++) begin
      tick();
      if (wif.MC_busy != 4'hF) begin
        grants++;
        for (int i = 0; i < NW; i++) if (!wif.MC_busy[i]) exp_wb = i;
        $display("grant busy=%b wb=%0d", wif.MC_busy, wif.wb_worker);
        checks++; if ($countones(~wif.MC_busy) != 1 || wif.wb_worker !== 2'(exp_wb)) begin errors++; $display("FAIL wb_onehot: busy=%b wb=%0d, expected one low bit at %0d", wif.MC_busy, wif.wb_worker, exp_wb); end
        own_tb = own_tb & wif.MC_busy;
      end
      if (wif.JW_start != 4'b0) begin
        $display("launch start=%b job=%0d", wif.JW_start, wif.job_id);
        checks++; if (wif.job_id !== JW'(launches)) begin errors++; $display("FAIL job_order: got %0d, expected %0d", wif.job_id, launches); end
        launches++;
        own_tb = own_tb | wif.JW_start;
      end
      if (frame_done) begin
        seen = 1'b1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_at_done: got %b, expected 0", busy); end
      end
      wif.JW_done = own_tb;
      if (seen) break;
    end
    checks++; if (!seen) begin errors++; $display("FAIL frame_done_seen: got 0, expected 1 within 200 cycles"); end
    checks++; if (launches != 8 || grants != 8) begin errors++; $display("FAIL frame_totals: launches=%0d grants=%0d, expected 8 8", launches, grants); end
    checks++; if (wif.timeout_err !== 4'b0) begin errors++; $display("FAIL no_tmo: got %b, expected 0000", wif.timeout_err); end
    wif.JW_done = '0;
    own_tb      = '0;
    tick();
    checks++; if (frame_done !== 1'b0 || busy !== 1'b0 || wif.JW_start !== 4'b0) begin errors++; $display("FAIL after_done: done=%b busy=%b start=%b, expected 0 0 0000", frame_done, busy, wif.JW_start); end
  endtask

  task automatic test_restart();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    checks++; if (busy !== 1'b1 || wif.JW_start !== 4'b0) begin errors++; $display("FAIL restart_lat1: busy=%b start=%b, expected 1 0000", busy, wif.JW_start); end
    tick();
    checks++; if ($countones(wif.JW_start) != 1 || wif.job_id !== 16'd0) begin errors++; $display("FAIL restart_job0: start=%b job=%0d, expected one-hot 0", wif.JW_start, wif.job_id); end
    tick();
    checks++; if ($countones(wif.JW_start) != 1 || wif.job_id !== 16'd1) begin errors++; $display("FAIL restart_job1: start=%b job=%0d, expected one-hot 1", wif.JW_start, wif.job_id); end
  endtask

  task automatic test_reset_mid();
    #3;
    n_rst = 1'b0;
    #1;
    checks++; if (wif.JW_start !== 4'b0 || wif.job_id !== 16'd0) begin errors++; $display("FAIL mid_rst_start: start=%b job=%0d, expected 0000 0", wif.JW_start, wif.job_id); end
    checks++; if (wif.MC_busy !== 4'hF || busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: mc_busy=%b busy=%b, expected 1111 0", wif.MC_busy, busy); end
    tick();
    n_rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (wif.JW_start !== 4'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_rst_idle_%0d: start=%b busy=%b, expected 0000 0", k, wif.JW_start, busy); end
    end
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    checks++; if (wif.JW_start !== 4'b0001 || wif.job_id !== 16'd0) begin errors++; $display("FAIL mid_rst_resume: start=%b job=%0d, expected 0001 0", wif.JW_start, wif.job_id); end
  endtask

`ifdef MC_TIMEOUT_EN
  task automatic test_timeout();
    int  l1 = -1;
    int  w1_launches = 0;
    bit  seen = 1'b0;
    n_rst       = 1'b0;
    wif.JW_done = '0;
    tick();
    n_rst        = 1'b1;
    own_tb       = '0;
    wif.JW_ready = 4'hF;
    frame_start  = 1'b1;
    tick();
    frame_start  = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      tick();
      if (wif.MC_busy != 4'hF) own_tb = own_tb & wif.MC_busy;
      if (wif.JW_start != 4'b0) begin
        own_tb = own_tb | wif.JW_start;
        if (wif.JW_start[1]) begin
          w1_launches++;
          if (l1 < 0) l1 = cyc;
        end
      end
      if (l1 >= 0 && cyc == l1 + 15) begin
        checks++; if (wif.timeout_err !== 4'b0000) begin errors++; $display("FAIL tmo_early: got %b, expected 0000", wif.timeout_err); end
      end
      if (l1 >= 0 && cyc == l1 + 16) begin
        $display("timeout err=%b", wif.timeout_err);
        checks++; if (wif.timeout_err !== 4'b0010) begin errors++; $display("FAIL tmo_set: got %b, expected 0010", wif.timeout_err); end
      end
      wif.JW_done = own_tb & 4'b1101;
      if (frame_done) begin
        seen = 1'b1;
        break;
      end
    end
    checks++; if (!seen) begin errors++; $display("FAIL tmo_frame_done: got 0, expected 1 within 400 cycles"); end
    checks++; if (w1_launches != 1) begin errors++; $display("FAIL tmo_w1_launches: got %0d, expected 1", w1_launches); end
    checks++; if (wif.timeout_err !== 4'b0010) begin errors++; $display("FAIL tmo_sticky: got %b, expected 0010", wif.timeout_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_dispatch();
    test_single_grant();
    test_back_to_back();
    test_full_frame();
    test_restart();
    test_reset_mid();
`ifdef MC_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end
endmodule

// File: doc/mc_dispatch.md
Name: mc_dispatch

Overview:
Master-controller side of the Julia worker handshake. The block owns a frame of NUM_JOBS jobs (pixel rows) and hands them to NUM_WORKERS worker control units. Each worker uses JW_ready, JW_start, JW_done and MC_busy. The block also arbitrates result write-back so that one worker is granted per cycle, and it signals when the whole frame is complete.

Parameters:
NUM_WORKERS, 4, number of attached workers (2..16)
NUM_JOBS, 480, jobs per frame (1..65535)
JOB_W, 16, job index width (clog2(NUM_JOBS) <= JOB_W)
TIMEOUT, 4096, watchdog limit in cycles (used only with MC_TIMEOUT_EN)

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
frame_start  in  1  one-cycle pulse; begins a frame when idle
frame_done  out  1  one-cycle pulse when all NUM_JOBS results are written back
busy  out  1  high from accepted frame_start until the frame_done cycle
JW_ready  in  NUM_WORKERS  worker i is idle and can accept a job
JW_start  out  NUM_WORKERS  one-hot, one-cycle job launch
job_id  out  JOB_W  index of the launched job; valid only while JW_start is nonzero
JW_done  in  NUM_WORKERS  worker i holds a result; held high until granted
MC_busy  out  NUM_WORKERS  active-high "bus busy"; a one-cycle low on bit i grants write-back to worker i
wb_worker  out  clog2(NUM_WORKERS)  index of the granted worker; valid when any MC_busy bit is low
timeout_err  out  NUM_WORKERS  sticky per-worker error (MC_TIMEOUT_EN only; otherwise tied 0)

Behaviour:
- Reset (asynchronous, effective at any time including mid-frame):
  - state = IDLE; JW_start = 0; job_id = 0; MC_busy = all 1s; frame_done = 0; busy = 0.
  - All counters and round-robin pointers = 0; timeout_err = 0.
- States:
  - IDLE: on frame_start go to DISPATCH; next_job = 0, completed = 0.
  - DISPATCH: launch jobs. When next_job == NUM_JOBS go to DRAIN.
  - DRAIN: no new launches; continue grants. When completed == NUM_JOBS go to DONE.
  - DONE: frame_done = 1 for one cycle, then IDLE.
- frame_start outside IDLE is ignored.
- Dispatch rules:
  - At most one launch per cycle.
  - Candidates: JW_ready[i] set, worker not currently owning a job, and worker not granted this cycle.
  - Choice is round-robin from the worker after the last launched one.
  - The launch is registered: JW_start[i] and job_id = next_job appear together for exactly 1 cycle, and next_job increments.
  - The worker is marked as owning a job until its grant.
  - JW_ready sampled during the launch cycle is ignored for that worker.
- Write-back rules:
  - At most one grant per cycle, round-robin over JW_done bits of owning workers. This pointer is independent of the dispatch pointer.
  - Grant = MC_busy[i] low for exactly 1 cycle, with wb_worker = i; completed increments and the ownership mark clears.
  - After a grant, JW_done[i] is masked for 1 cycle so the worker has time to drop it.
- Simultaneous events:
  - A launch and a grant to different workers in the same cycle are both allowed.
  - JW_done from a worker that owns no job is ignored.
- Latency: frame_start to the first JW_start is 2 cycles when a worker is ready.
- completed never exceeds NUM_JOBS; the DONE transition is compared with ==.

Optional Feature:
MC_TIMEOUT_EN
- Defined:
  - Each owning worker has a counter that clears at launch and increments every cycle until grant.
  - On reaching TIMEOUT: timeout_err[i] is set (sticky until reset); ownership clears; completed increments, so the frame still finishes.
  - Worker i is then excluded from all future dispatch.
- Undefined: no counters; timeout_err is constant 0.

Decomposition:
- Shared package mc_pkg: state enum (IDLE, DISPATCH, DRAIN, DONE) and default width constants.
- Sub-module rr_arbiter, parameterised by width, with request, one-hot grant and an advance strobe. It is instantiated twice: dispatch and write-back.

Test Plan:
- Reset then frame_start, NUM_WORKERS=4, NUM_JOBS=8, all JW_ready=1 -> JW_start is 0001, 0010, 0100, 1000 on consecutive cycles with job_id 0..3, then no launches until grants.
- Worker 2 raises JW_done -> MC_busy[2] low for exactly 1 cycle, wb_worker=2; in the next cycle worker 2 is eligible again and receives job_id 4.
- JW_done on workers 0 and 3 in the same cycle -> grants issued on consecutive cycles in round-robin order, never both low together.
- Full frame of 8 jobs -> frame_done pulses once; busy falls in that same cycle; a second frame_start restarts job_id at 0.
- n_rst pulled low mid-DISPATCH -> all outputs return to reset values immediately; frame_start is needed to resume.
- MC_TIMEOUT_EN with TIMEOUT=16, worker 1 never raises JW_done -> timeout_err=0010 at cycle 16 after launch; worker 1 is never started again; frame_done still pulses.
